// File: rtl/icache.sv
// Direct-mapped instruction cache: 16 one-word frames, tag = addr[31:6], index = addr[5:2].
// Latency: hits are combinational in IDLE; a miss costs one IDLE cycle plus FETCH cycles until iwait drops.
// Backpressure: stalls in FETCH while memory_control holds iwait; iflush aborts any fill and forces IDLE.
module icache (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [15:0] hitcnt
);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_valid;
  logic [25:0] r_tag  [16];
  logic [31:0] r_data [16];
  logic [31:0] r_missaddr;
  logic [15:0] r_hitcnt;

  logic [3:0]  w_index;
  logic [25:0] w_tag;
  logic [3:0]  w_fill_index;
  logic        w_lookup_hit;
  logic        w_miss;
  logic        w_fill;
  logic        w_unused_addr_bits;

  assign w_index            = imemaddr[5:2];
  assign w_tag              = imemaddr[31:6];
  assign w_fill_index       = r_missaddr[5:2];
  // Byte offset within the word never matters for a word-per-frame cache.
  assign w_unused_addr_bits = &{1'b0, imemaddr[1:0]};

  // A flush in the same cycle masks the lookup so a stale frame can never be returned.
  assign w_lookup_hit = imemREN & r_valid[w_index] & (r_tag[w_index] == w_tag) & ~iflush;
  assign w_miss       = (r_state == IDLE) & imemREN & ~w_lookup_hit & ~iflush;
  assign w_fill       = (r_state == FETCH) & ~iwait & ~iflush;

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: a miss starts a fetch, memory completion or a flush returns to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_miss) w_next = FETCH;
      FETCH:   if (!iwait) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (iflush) w_next = IDLE;
  end

  // Output logic: hits only in IDLE, memory request only in FETCH, zeros otherwise.
  always_comb begin
    ihit     = (r_state == IDLE) & w_lookup_hit;
    imemload = ihit ? r_data[w_index] : 32'd0;
    iREN     = (r_state == FETCH);
    iaddr    = (r_state == FETCH) ? r_missaddr : 32'd0;
  end

  // Miss address is captured once on the miss and held through the whole fetch.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)       r_missaddr <= 32'd0;
    else if (w_miss) r_missaddr <= {imemaddr[31:2], 2'b00};
  end

  // Frame storage: flush clears every valid bit; a fill overwrites its frame unconditionally.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= 16'd0;
      for (int i = 0; i < 16; i++) begin
        r_tag[i]  <= 26'd0;
        r_data[i] <= 32'd0;
      end
    end else if (iflush) begin
      r_valid <= 16'd0;
    end else if (w_fill) begin
      r_valid[w_fill_index] <= 1'b1;
      r_tag[w_fill_index]   <= r_missaddr[31:6];
      r_data[w_fill_index]  <= iload;
    end
  end

  // Saturating hit counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                             r_hitcnt <= 16'd0;
    else if (ihit && r_hitcnt != 16'hFFFF) r_hitcnt <= r_hitcnt + 16'd1;
  end

  assign hitcnt = r_hitcnt;

endmodule

// File: tb/tb_icache.sv
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [15:0] hitcnt;

  icache dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .iflush   (iflush),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .hitcnt   (hitcnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        flush;
    logic        iw;
    logic [31:0] ld;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_ren;
    logic [31:0] e_addr;
    logic [15:0] e_hc;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ren, input logic [31:0] addr, input logic flush, input logic iw,
                     input logic [31:0] ld, input logic e_hit, input logic [31:0] e_load,
                     input logic e_ren, input logic [31:0] e_addr, input logic [15:0] e_hc);
    vec_t v;
    v.ren = ren; v.addr = addr; v.flush = flush; v.iw = iw; v.ld = ld;
    v.e_hit = e_hit; v.e_load = e_load; v.e_ren = e_ren; v.e_addr = e_addr; v.e_hc = e_hc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ren, input logic [31:0] addr, input logic flush,
                       input logic iw, input logic [31:0] ld);
    imemREN = ren; imemaddr = addr; iflush = flush; iwait = iw; iload = ld;
  endtask

  task automatic check_outs(input string tag, input logic e_hit, input logic [31:0] e_load,
                            input logic e_ren, input logic [31:0] e_addr, input logic [15:0] e_hc);
    check({tag, ".ihit"},     {31'd0, ihit}, {31'd0, e_hit});
    check({tag, ".imemload"}, imemload,      e_load);
    check({tag, ".iREN"},     {31'd0, iREN}, {31'd0, e_ren});
    check({tag, ".iaddr"},    iaddr,         e_addr);
    check({tag, ".hitcnt"},   {16'd0, hitcnt}, {16'd0, e_hc});
  endtask

  initial begin
    // Each row: inputs for one cycle, outputs expected before that cycle's edge.
    //   ren addr          fl iw iload          hit load           iren iaddr         hitcnt
    // Cold miss on 0x04 with two wait cycles.
    add(1, 32'h0000_0004, 0, 1, 32'h0,         0, 32'h0,          0, 32'h0,          16'd0);
    add(1, 32'h0000_0004, 0, 1, 32'h0,         0, 32'h0,          1, 32'h0000_0004,  16'd0);
    add(1, 32'h0000_0004, 0, 1, 32'h0,         0, 32'h0,          1, 32'h0000_0004,  16'd0);
    add(1, 32'h0000_0004, 0, 0, 32'h8C01_0000, 0, 32'h0,          1, 32'h0000_0004,  16'd0);
    // Repeated hits.
    add(1, 32'h0000_0004, 0, 1, 32'h0,         1, 32'h8C01_0000,  0, 32'h0,          16'd0);
    add(1, 32'h0000_0004, 0, 1, 32'h0,         1, 32'h8C01_0000,  0, 32'h0,          16'd1);
    add(1, 32'h0000_0007, 0, 1, 32'h0,         1, 32'h8C01_0000,  0, 32'h0,          16'd2);
    add(1, 32'h0000_0004, 0, 1, 32'h0,         1, 32'h8C01_0000,  0, 32'h0,          16'd3);
    // No request: idle.
    add(0, 32'h0000_0004, 0, 0, 32'h0,         0, 32'h0,          0, 32'h0,          16'd4);
    add(0, 32'h0000_0044, 0, 0, 32'h0,         0, 32'h0,          0, 32'h0,          16'd4);
    // Conflict on index 1.
    add(1, 32'h0000_0044, 0, 0, 32'h1111_1111, 0, 32'h0,          0, 32'h0,          16'd4);
    add(1, 32'h0000_0044, 0, 0, 32'h1111_1111, 0, 32'h0,          1, 32'h0000_0044,  16'd4);
    add(1, 32'h0000_0044, 0, 1, 32'h0,         1, 32'h1111_1111,  0, 32'h0,          16'd4);
    add(1, 32'h0000_0004, 0, 1, 32'h0,         0, 32'h0,          0, 32'h0,          16'd5);
    add(1, 32'h0000_0004, 0, 0, 32'h8C01_0000, 0, 32'h0,          1, 32'h0000_0004,  16'd5);
    add(1, 32'h0000_0004, 0, 1, 32'h0,         1, 32'h8C01_0000,  0, 32'h0,          16'd5);
    // Address change while waiting.
    add(1, 32'h0000_0010, 0, 1, 32'h0,         0, 32'h0,          0, 32'h0,          16'd6);
    add(1, 32'h0000_0020, 0, 1, 32'h0,         0, 32'h0,          1, 32'h0000_0010,  16'd6);
    add(0, 32'h0000_0020, 0, 0, 32'h2222_2222, 0, 32'h0,          1, 32'h0000_0010,  16'd6);
    add(1, 32'h0000_0020, 0, 1, 32'h0,         0, 32'h0,          0, 32'h0,          16'd6);
    add(1, 32'h0000_0020, 0, 0, 32'h3333_3333, 0, 32'h0,          1, 32'h0000_0020,  16'd6);
    add(1, 32'h0000_0010, 0, 1, 32'h0,         1, 32'h2222_2222,  0, 32'h0,          16'd6);
    add(1, 32'h0000_0020, 0, 1, 32'h0,         1, 32'h3333_3333,  0, 32'h0,          16'd7);
    // Flush in IDLE masks the hit, then flush coincident with a fill.
    add(1, 32'h0000_0010, 1, 1, 32'h0,         0, 32'h0,          0, 32'h0,          16'd8);
    add(1, 32'h0000_0010, 0, 1, 32'h0,         0, 32'h0,          0, 32'h0,          16'd8);
    add(1, 32'h0000_0010, 1, 0, 32'h4444_4444, 0, 32'h0,          1, 32'h0000_0010,  16'd8);
    add(1, 32'h0000_0020, 0, 1, 32'h0,         0, 32'h0,          0, 32'h0,          16'd8);
    add(1, 32'h0000_0020, 0, 0, 32'h5555_5555, 0, 32'h0,          1, 32'h0000_0020,  16'd8);
    add(1, 32'h0000_0004, 0, 1, 32'h0,         0, 32'h0,          0, 32'h0,          16'd8);
    add(1, 32'h0000_0004, 0, 0, 32'hAAAA_0004, 0, 32'h0,          1, 32'h0000_0004,  16'd8);
    add(1, 32'h0000_0010, 0, 1, 32'h0,         0, 32'h0,          0, 32'h0,          16'd8);
    add(1, 32'h0000_0010, 0, 0, 32'h6666_6666, 0, 32'h0,          1, 32'h0000_0010,  16'd8);
    add(1, 32'h0000_0010, 0, 1, 32'h0,         1, 32'h6666_6666,  0, 32'h0,          16'd8);
    add(1, 32'h0000_0020, 0, 1, 32'h0,         1, 32'h5555_5555,  0, 32'h0,          16'd9);

    // Reset state.
    nRST = 1'b0;
    drive(0, 32'h0, 0, 1, 32'h0);
    #2;
    check_outs("reset", 0, 32'h0, 0, 32'h0, 16'd0);
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // Table-driven section.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ren, vecs[i].addr, vecs[i].flush, vecs[i].iw, vecs[i].ld);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].e_hit, vecs[i].e_load,
                 vecs[i].e_ren, vecs[i].e_addr, vecs[i].e_hc);
      @(posedge CLK);
      #1;
    end

    // Saturation: hitcnt is 10 here; hit until 0xFFFE.
    drive(1, 32'h0000_0010, 0, 1, 32'h0);
    repeat (16'hFFFE - 16'd10) @(posedge CLK);
    #1;
    check("sat.pre", {16'd0, hitcnt}, 32'h0000_FFFE);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sat.hit%0d", k), {31'd0, ihit}, 32'd1);
      @(posedge CLK);
      #1;
      check($sformatf("sat.cnt%0d", k), {16'd0, hitcnt}, 32'h0000_FFFF);
    end

    // Reset asserted mid-fetch.
    drive(1, 32'h0000_0080, 0, 1, 32'h0);
    #1;
    check("rf.miss", {31'd0, ihit}, 32'd0);
    @(posedge CLK);
    #1;
    check("rf.iREN", {31'd0, iREN}, 32'd1);
    check("rf.iaddr", iaddr, 32'h0000_0080);
    #2 nRST = 1'b0;
    #1;
    check_outs("rf.async", 0, 32'h0, 0, 32'h0, 16'd0);
    drive(1, 32'h0000_0080, 0, 0, 32'h7777_7777);
    @(posedge CLK);
    #1 nRST = 1'b1;
    drive(1, 32'h0000_0080, 0, 1, 32'h0);
    #1;
    check_outs("rf.idle", 0, 32'h0, 0, 32'h0, 16'd0);
    @(posedge CLK);
    #1;
    check("rf.refetch", {31'd0, iREN}, 32'd1);
    check("rf.refaddr", iaddr, 32'h0000_0080);
    drive(1, 32'h0000_0080, 0, 0, 32'h9999_9999);
    @(posedge CLK);
    #1;
    drive(1, 32'h0000_0080, 0, 1, 32'h0);
    #1;
    check_outs("rf.hit", 1, 32'h9999_9999, 0, 32'h0, 16'd0);
    drive(1, 32'h0000_0010, 0, 1, 32'h0);
    #1;
    check("rf.cleared", {31'd0, ihit}, 32'd0);
    @(posedge CLK);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have no parameters: direct-mapped, 16 frames, one 32-bit word per frame.
REQ-002 The block SHALL have the port: CLK  input  1  rising-edge clock.
REQ-003 The block SHALL have the port: nRST  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have the port: imemREN  input  1  datapath instruction fetch request.
REQ-005 The block SHALL have the port: imemaddr  input  32  fetch byte address.
REQ-006 The block SHALL have the port: iflush  input  1  invalidate all frames.
REQ-007 The block SHALL have the port: ihit  output  1  imemload valid this cycle.
REQ-008 The block SHALL have the port: imemload  output  32  fetched instruction.
REQ-009 The block SHALL have the port: iREN  output  1  read request to memory_control.
REQ-010 The block SHALL have the port: iaddr  output  32  word-aligned read address to memory_control.
REQ-011 The block SHALL have the port: iwait  input  1  memory_control busy; the read completes in any cycle where iREN=1 and iwait=0.
REQ-012 The block SHALL have the port: iload  input  32  read data from memory_control, valid when iwait=0.
REQ-013 The block SHALL have the port: hitcnt  output  16  saturating hit count.

Function
REQ-014 Address split SHALL be: [1:0] ignored; index = [5:2]; tag = [31:6] (26 bits).
REQ-015 Each frame SHALL hold valid (1), tag (26) and data (32).
REQ-016 The FSM SHALL have two states: IDLE and FETCH.
REQ-017 In IDLE, ihit SHALL be combinational: imemREN & valid[index] & (tag[index]==imemaddr[31:6]) & ~iflush.
REQ-018 imemload SHALL equal data[index] when ihit=1, else 0.
REQ-019 In IDLE, imemREN=1 with no hit and iflush=0 SHALL latch {imemaddr[31:2],2'b00} into missaddr and go to FETCH on the next edge.
REQ-020 In IDLE, iREN SHALL be 0 and iaddr SHALL be 0.
REQ-021 In FETCH, iREN SHALL be 1 and iaddr SHALL equal missaddr; ihit SHALL be 0.
REQ-022 In FETCH with iwait=0, the edge SHALL write valid=1, tag=missaddr[31:6] and data=iload into frame missaddr[5:2], then return to IDLE.
REQ-023 In FETCH with iwait=1, the block SHALL hold state; changes to imemaddr or imemREN SHALL NOT alter missaddr.
REQ-024 Minimum miss latency SHALL be: miss cycle, one FETCH cycle, then ihit=1 in the following IDLE cycle if the request is unchanged (3 cycles from request to ihit).
REQ-025 If imemaddr differs after the fill, the block SHALL treat it as a new lookup, which may miss.
REQ-026 A fill SHALL overwrite the frame at that index regardless of prior contents (conflict eviction).
REQ-027 iflush=1 SHALL clear all valid bits on the edge, force IDLE, and discard any fill completing in that cycle; tags and data MAY remain.
REQ-028 hitcnt SHALL increment on every edge where ihit=1 and SHALL saturate at 16'hFFFF.
REQ-029 imemREN=0 in IDLE SHALL cause no state change and no memory request.

Reset
REQ-030 nRST=0 SHALL asynchronously force IDLE, clear all valid bits, clear missaddr and hitcnt to 0, and drive ihit=0, imemload=0, iREN=0 and iaddr=0.
REQ-031 Reset asserted during FETCH SHALL abort the request with no frame written; after release the block SHALL be in IDLE.

Verification
REQ-032 Cold miss: after reset, imemREN=1, imemaddr=0x00000004, memory returns iload=0x8C010000 after 2 iwait cycles -> iREN=1 with iaddr=0x00000004 until iwait drops; the next cycle gives ihit=1, imemload=0x8C010000, hitcnt=1.
REQ-033 Hit: repeat fetch of 0x00000004 -> ihit=1 in the same cycle, iREN stays 0, and hitcnt increments each cycle.
REQ-034 Conflict: fill 0x00000004, then fetch 0x00000044 (same index 1, different tag) -> miss and refill; a subsequent fetch of 0x00000004 misses again.
REQ-035 Address change during FETCH: miss on 0x10, switch imemaddr to 0x20 while iwait=1 -> iaddr stays 0x10, frame 4 is filled, then 0x20 misses.
REQ-036 Flush: with frames filled, pulse iflush for one cycle, including once coincident with iwait=0 in FETCH -> all subsequent fetches miss and the coincident fill is not retained.
REQ-037 Saturation/reset: preload hitcnt to 16'hFFFE through hits, then give 3 more hits -> hitcnt=16'hFFFF; assert nRST mid-FETCH -> all outputs 0 immediately.
